// File: rtl/ascii_bin_pkg.sv
// Shared constants and state encoding for the ASCII decimal to binary converter.
package ascii_bin_pkg;

  localparam int         DIGITS_DEF = 4;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    MAC,
    DONE
  } state_t;

endpackage

// File: rtl/ascii_to_bin_digit_check.sv
// Classifies one ASCII byte as a decimal digit and extracts its value.
module ascii_digit_check
  import ascii_bin_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_valid,
  output logic [3:0] o_digit
);

  assign o_valid = (i_byte >= ASCII_ZERO) && (i_byte <= ASCII_NINE);
  // Low nibble equals the digit value for '0'..'9'.
  assign o_digit = i_byte[3:0];

endmodule

// File: rtl/ascii_to_bin.sv
// Converts a word of ASCII decimal digits (MSD in the top byte) to unsigned binary,
// one multiply-accumulate step per cycle; cross_ready low freezes everything.
//
// state | meaning
// IDLE  | waiting for ascii_valid; outputs hold the last result
// CHECK | validate every latched byte
// MAC   | acc = acc*10 + digit, one digit per cycle, MSD first
// DONE  | publish bin_out / err, raise bin_ready
module ascii_to_bin
  import ascii_bin_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*DIGITS-1:0]   ascii_in,
  input  logic                  ascii_valid,
  input  logic                  cross_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  bin_ready,
  output logic                  err
);

  localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t              r_state, w_state_nx;
  logic [8*DIGITS-1:0] r_word, w_word_nx;
  logic [BIN_W-1:0]    r_acc, w_acc_nx;
  logic [BIN_W-1:0]    r_bin, w_bin_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic                r_bad, w_bad_nx;
  logic                r_rdy, w_rdy_nx;
  logic                r_err, w_err_nx;

  logic [DIGITS-1:0]   w_dig_ok;
  logic [3:0]          w_digit [DIGITS];
  logic [3:0]          w_cur;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    ascii_digit_check u_chk (
      .i_byte  (r_word[8*g +: 8]),
      .o_valid (w_dig_ok[g]),
      .o_digit (w_digit[g])
    );
  end

  // Index 0 walks from the most significant byte downward.
  assign w_cur = w_digit[LAST_IDX - r_idx];

  always_comb begin
    w_state_nx = r_state;
    w_word_nx  = r_word;
    w_acc_nx   = r_acc;
    w_bin_nx   = r_bin;
    w_idx_nx   = r_idx;
    w_bad_nx   = r_bad;
    w_rdy_nx   = r_rdy;
    w_err_nx   = r_err;
    if (cross_ready) begin
      case (r_state)
        IDLE: begin
          if (ascii_valid) begin
            w_word_nx  = ascii_in;
            w_rdy_nx   = 1'b0;
            w_err_nx   = 1'b0;
            w_state_nx = CHECK;
          end
        end
        CHECK: begin
          if (&w_dig_ok) begin
            w_bad_nx   = 1'b0;
            w_acc_nx   = '0;
            w_idx_nx   = '0;
            w_state_nx = MAC;
          end else begin
            w_bad_nx   = 1'b1;
            w_state_nx = DONE;
          end
        end
        MAC: begin
          w_acc_nx = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_cur);
          if (r_idx == LAST_IDX) begin
            w_idx_nx   = '0;
            w_state_nx = DONE;
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end
        DONE: begin
          w_bin_nx   = r_bad ? '0 : r_acc;
          w_err_nx   = r_bad;
          w_rdy_nx   = 1'b1;
          w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_acc   <= '0;
      r_bin   <= '0;
      r_idx   <= '0;
      r_bad   <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_word  <= w_word_nx;
      r_acc   <= w_acc_nx;
      r_bin   <= w_bin_nx;
      r_idx   <= w_idx_nx;
      r_bad   <= w_bad_nx;
      r_rdy   <= w_rdy_nx;
      r_err   <= w_err_nx;
    end
  end

  assign bin_out   = r_bin;
  assign bin_ready = r_rdy;
  assign err       = r_err;

endmodule

// File: tb/tb_ascii_to_bin.sv
// Self-checking bench for ascii_to_bin: directed corner words plus random words
// compared against a decimal-parsing reference model.
module tb_ascii_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                clk = 1'b0;
  logic                rst;
  logic [8*DIGITS-1:0] ascii_in;
  logic                ascii_valid;
  logic                cross_ready;
  logic [BIN_W-1:0]    bin_out;
  logic                bin_ready;
  logic                err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] prev_out = '0;
  int          val;
  bit          bad;
  logic [31:0] bw [4];

  ascii_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .cross_ready (cross_ready),
    .bin_out     (bin_out),
    .bin_ready   (bin_ready),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: parse the word as a decimal string, MSD in the top byte.
  function automatic void ref_conv(input logic [31:0] w, output int v, output bit b);
    int c;
    v = 0;
    b = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      c = int'(w[8*i +: 8]);
      if (c < 48 || c > 57) b = 1'b1;
      else v = v * 10 + (c - 48);
    end
    if (b) v = 0;
  endfunction

  function automatic logic [31:0] gen_word(input bit digits_only);
    logic [31:0] w;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_only || $urandom_range(0, 4) != 0)
        w[8*i +: 8] = 8'(8'h30 + $urandom_range(0, 9));
      else
        w[8*i +: 8] = 8'($urandom_range(0, 255));
    end
    return w;
  endfunction

  // Issue one request from IDLE; cross_ready is dropped for enabled-edge numbers
  // stall_at+1 .. stall_at+stall_len counted from the accepting edge.
  task automatic run_word(input logic [31:0] w, input int stall_at, input int stall_len,
                          input string tag);
    int  v;
    bit  b;
    int  lat;
    int  exp_lat;
    ref_conv(w, v, b);
    exp_lat = (b ? 2 : 6) + stall_len;
    ascii_in    = w;
    ascii_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/rdy_clr"}, 32'(bin_ready), 32'd0);
    chk({tag, "/err_clr"}, 32'(err), 32'd0);
    ascii_valid = 1'b0;
    ascii_in    = $urandom;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      cross_ready = !(k > stall_at && k <= stall_at + stall_len);
      @(posedge clk); #1;
      if (!cross_ready) begin
        chk({tag, "/frz_rdy"}, 32'(bin_ready), 32'd0);
        chk({tag, "/frz_out"}, 32'(bin_out), prev_out);
      end
      if (bin_ready) begin
        lat = k;
        break;
      end
    end
    cross_ready = 1'b1;
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/bin_out"}, 32'(bin_out), 32'(v));
    chk({tag, "/err"}, 32'(err), 32'(b));
    prev_out = 32'(v);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    chk({tag, "/hold_rdy"}, 32'(bin_ready), 32'd1);
    chk({tag, "/hold_out"}, 32'(bin_out), 32'(v));
  endtask

  initial begin
    rst         = 1'b1;
    ascii_valid = 1'b1;
    cross_ready = 1'b1;
    ascii_in    = 32'h31323334;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/bin_out", 32'(bin_out), 32'd0);
    chk("reset/bin_ready", 32'(bin_ready), 32'd0);
    chk("reset/err", 32'(err), 32'd0);
    ascii_valid = 1'b0;
    rst         = 1'b0;
    @(posedge clk); #1;
    chk("idle/no_req", 32'(bin_ready), 32'd0);

    run_word(32'h31323334, 0, 0, "w1234");
    chk("w1234/const", 32'(bin_out), 32'd1234);
    run_word(32'h39393939, 0, 0, "w9999");
    chk("w9999/const", 32'(bin_out), 32'd9999);
    run_word(32'h30303030, 0, 0, "w0000");
    run_word(32'h31324134, 0, 0, "w12A4");
    chk("w12A4/err_const", 32'(err), 32'd1);
    run_word(32'h31322F34, 0, 0, "w12_2F_4");
    run_word(32'h333A3030, 0, 0, "w3_3A_00");
    run_word(32'h30303432, 2, 3, "stall0042");
    chk("stall0042/const", 32'(bin_out), 32'd42);

    // Reset in the middle of MAC for "5678".
    ascii_in    = 32'h35363738;
    ascii_valid = 1'b1;
    @(posedge clk); #1;
    ascii_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid/bin_out", 32'(bin_out), 32'd0);
    chk("rstmid/bin_ready", 32'(bin_ready), 32'd0);
    chk("rstmid/err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rstmid/no_result", 32'(bin_ready), 32'd0);
    prev_out = '0;
    run_word(32'h30303037, 0, 0, "w0007");

    // ascii_valid held high: a new word accepted every 7 cycles.
    for (int i = 0; i < 4; i++) bw[i] = gen_word(1'b1);
    ascii_in    = bw[0];
    ascii_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk("b2b/accept_clr", 32'(bin_ready), 32'd0);
      ascii_in = $urandom;
      repeat (4) @(posedge clk);
      #1;
      if (j < 3) ascii_in = bw[j+1];
      else ascii_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      ref_conv(bw[j], val, bad);
      chk("b2b/ready", 32'(bin_ready), 32'd1);
      chk("b2b/bin_out", 32'(bin_out), 32'(val));
      prev_out = 32'(val);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 24; n++)
      run_word(gen_word(1'b0), 0, int'($urandom_range(0, 2)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
